mio_bus_arbiter: RTL and testbench



---
 rtl/mio_arb_pkg.sv | 19 +
 rtl/rr_arb2.sv | 26 ++
 rtl/mio_bus_arbiter.sv | 147 ++++++++++++++
 tb/tb_mio_bus_arbiter.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mio_arb_pkg.sv
// ---------------------------------------------------------------------------
// mio_arb_pkg
// Shared types and constants for the MIO bus arbiter.
//   arb_state_t           : transaction phase (IDLE / ACCESS / DONE)
//   CNT_W                 : width of the access-window down-counter
//   DEFAULT_ACCESS_CYCLES : default bus hold time per transaction
// ---------------------------------------------------------------------------
package mio_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } arb_state_t;

    localparam int CNT_W                 = 4;
    localparam int DEFAULT_ACCESS_CYCLES = 2;

endpackage

// File: rtl/rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
// Two-input round-robin picker, purely combinational.
//   req[1:0] : request vector, bit i = master i
//   last     : index of the master granted most recently
//   grant    : index of the chosen master (meaningful when valid = 1)
//   valid    : at least one master is requesting
// On a tie the master that did not win last time is chosen.
// ---------------------------------------------------------------------------
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       grant,
    output logic       valid
);

    always_comb begin
        valid = |req;
        if (&req) begin
            grant = ~last;
        end else begin
            grant = req[1];
        end
    end

endmodule

// File: rtl/mio_bus_arbiter.sv
// ---------------------------------------------------------------------------
// mio_bus_arbiter
// Shares the single MIO peripheral bus between CPU core 0 and core 1.
// A granted master's direction, address and write data are latched and held
// on the bus for ACCESS_CYCLES cycles; read data is captured on the last
// access edge and returned with a one-cycle acknowledge.
//
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   mN_req/we/addr/wdata     : master N request (held until mN_ack)
//   mN_ack, mN_rdata         : completion pulse and read data for master N
//   mem_w, mem_r             : bus write / read strobes
//   addr_bus, Cpu_data2bus   : bus address and write data
//   Cpu_data4bus             : bus read data
//   owner                    : master of the current or last transaction
//   busy                     : transaction in progress (ACCESS or DONE)
// ---------------------------------------------------------------------------
module mio_bus_arbiter
    import mio_arb_pkg::*;
#(
    parameter int ACCESS_CYCLES = DEFAULT_ACCESS_CYCLES
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_ack,
    output logic [31:0] m0_rdata,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_ack,
    output logic [31:0] m1_rdata,
    output logic        mem_w,
    output logic        mem_r,
    output logic [31:0] addr_bus,
    output logic [31:0] Cpu_data2bus,
    input  logic [31:0] Cpu_data4bus,
    output logic        owner,
    output logic        busy
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ACCESS_CYCLES - 1);

    arb_state_t       state;
    arb_state_t       state_next;
    logic [CNT_W-1:0] cnt;
    logic             last;
    logic             sel_we;
    logic [31:0]      sel_addr;
    logic [31:0]      sel_wdata;
    logic             pick;
    logic             pick_valid;
    logic             grant_now;
    logic             access_end;

    rr_arb2 u_rr_arb2 (
        .req   ({m1_req, m0_req}),
        .last  (last),
        .grant (pick),
        .valid (pick_valid)
    );

    assign grant_now  = (state == IDLE) && pick_valid;
    assign access_end = (state == ACCESS) && (cnt == '0);

    // State register.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    // NOTE: a default is assigned before any branch so every path writes
    // state_next; a missing path here would infer a latch.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (pick_valid) state_next = ACCESS;
            ACCESS:  if (cnt == '0)  state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Bus drive: only ACCESS puts anything on the bus.
    always_comb begin
        mem_w        = 1'b0;
        mem_r        = 1'b0;
        addr_bus     = '0;
        Cpu_data2bus = '0;
        busy         = (state != IDLE);
        if (state == ACCESS) begin
            mem_w        = sel_we;
            mem_r        = ~sel_we;
            addr_bus     = sel_addr;
            Cpu_data2bus = sel_wdata;
        end
    end

    // Control and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            last     <= 1'b1;   // core 0 wins the first tie
            owner    <= 1'b0;
            m0_ack   <= 1'b0;
            m1_ack   <= 1'b0;
            m0_rdata <= '0;
            m1_rdata <= '0;
        end else begin
            m0_ack <= access_end && (owner == 1'b0);
            m1_ack <= access_end && (owner == 1'b1);
            if (grant_now) begin
                cnt   <= CNT_LOAD;
                last  <= pick;
                owner <= pick;
            end else if ((state == ACCESS) && (cnt != '0)) begin
                cnt <= cnt - 1'b1;
            end
            if (access_end) begin
                if (owner) m1_rdata <= Cpu_data4bus;
                else       m0_rdata <= Cpu_data4bus;
            end
        end
    end

    // Latched request payload.
    // NOTE: deliberately not reset -- it is only visible during ACCESS, and
    // ACCESS can only be entered through a grant, which loads it.
    always_ff @(posedge clk) begin
        if (grant_now) begin
            sel_we    <= pick ? m1_we    : m0_we;
            sel_addr  <= pick ? m1_addr  : m0_addr;
            sel_wdata <= pick ? m1_wdata : m0_wdata;
        end
    end

endmodule

// File: tb/tb_mio_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mio_bus_arbiter
// Directed scenarios followed by randomized traffic scored against a
// timeline model: each grant is decided from the round-robin rule and then
// the expected bus activity, acknowledge and read data are written into a
// per-cycle table that the DUT outputs are compared against.
// ---------------------------------------------------------------------------
module tb_mio_bus_arbiter;

    localparam int AC = 2;
    localparam int TL = 4096;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_ack, m1_ack;
    logic [31:0] m0_rdata, m1_rdata;
    logic        mem_w, mem_r;
    logic [31:0] addr_bus, Cpu_data2bus, Cpu_data4bus;
    logic        owner, busy;

    mio_bus_arbiter #(.ACCESS_CYCLES(AC)) dut (
        .clk          (clk),
        .rst          (rst),
        .m0_req       (m0_req),
        .m0_we        (m0_we),
        .m0_addr      (m0_addr),
        .m0_wdata     (m0_wdata),
        .m0_ack       (m0_ack),
        .m0_rdata     (m0_rdata),
        .m1_req       (m1_req),
        .m1_we        (m1_we),
        .m1_addr      (m1_addr),
        .m1_wdata     (m1_wdata),
        .m1_ack       (m1_ack),
        .m1_rdata     (m1_rdata),
        .mem_w        (mem_w),
        .mem_r        (mem_r),
        .addr_bus     (addr_bus),
        .Cpu_data2bus (Cpu_data2bus),
        .Cpu_data4bus (Cpu_data4bus),
        .owner        (owner),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // {mem_w, mem_r, addr_bus, Cpu_data2bus}
    function automatic logic [65:0] bus_now();
        return {mem_w, mem_r, addr_bus, Cpu_data2bus};
    endfunction

    // {m0_ack, m1_ack, owner, busy}
    function automatic logic [3:0] ctl_now();
        return {m0_ack, m1_ack, owner, busy};
    endfunction

    task automatic do_reset();
        rst          = 1'b1;
        m0_req       = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
        m1_req       = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
        Cpu_data4bus = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // ---------------- timeline model for randomized traffic ----------------
    typedef struct packed {
        logic        mem_w;
        logic        mem_r;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        ack0;
        logic        ack1;
        logic        owner;
        logic        busy;
        logic [31:0] rdata;
    } exp_t;

    exp_t        tl     [TL];
    logic [31:0] bus_rd [TL];

    task automatic run_engine(input string name, input int ncyc, input int p_req);
        logic        r      [2];
        logic        w_we   [2];
        logic [31:0] w_addr [2];
        logic [31:0] w_wdat [2];
        logic        flight [2];
        int          ack_at [2];
        int          gap    [2];
        logic [31:0] rd     [2];
        int          free_at = 0;
        int          mlast   = 1;
        logic        mowner  = 1'b0;
        int          win;

        for (int i = 0; i < TL; i++) begin
            tl[i]     = '0;
            bus_rd[i] = $urandom;
        end
        for (int i = 0; i < 2; i++) begin
            r[i] = 1'b0; w_we[i] = 1'b0; w_addr[i] = '0; w_wdat[i] = '0;
            flight[i] = 1'b0; ack_at[i] = -1; gap[i] = 0; rd[i] = '0;
        end

        do_reset();
        for (int c = 0; c < ncyc; c++) begin
            if (c > 0) @(negedge clk);

            // Compare this cycle against the timeline.
            if (tl[c].busy) mowner = tl[c].owner;
            if (tl[c].ack0) rd[0] = tl[c].rdata;
            if (tl[c].ack1) rd[1] = tl[c].rdata;
            check({name, "_bus"}, bus_now(), {tl[c].mem_w, tl[c].mem_r, tl[c].addr, tl[c].wdata});
            check({name, "_ctl"}, ctl_now(), {tl[c].ack0, tl[c].ack1, mowner, tl[c].busy});
            check({name, "_rdata"}, {m0_rdata, m1_rdata}, {rd[0], rd[1]});
            check({name, "_one_ack"}, m0_ack & m1_ack, 1'b0);

            // Master behaviour: drop on ack, scramble inputs while latched, re-request.
            for (int i = 0; i < 2; i++) begin
                if (flight[i] && ack_at[i] == c) begin
                    r[i]      = 1'b0;
                    flight[i] = 1'b0;
                    gap[i]    = (p_req >= 100) ? 0 : $urandom_range(0, 3);
                end else if (flight[i]) begin
                    w_we[i]   = 1'($urandom_range(0, 1));
                    w_addr[i] = $urandom;
                    w_wdat[i] = $urandom;
                end else if (!r[i]) begin
                    if (gap[i] > 0) begin
                        gap[i]--;
                    end else if ($urandom_range(0, 99) < p_req) begin
                        r[i]      = 1'b1;
                        w_we[i]   = 1'($urandom_range(0, 1));
                        w_addr[i] = $urandom;
                        w_wdat[i] = $urandom;
                    end
                end
            end
            m0_req = r[0]; m0_we = w_we[0]; m0_addr = w_addr[0]; m0_wdata = w_wdat[0];
            m1_req = r[1]; m1_we = w_we[1]; m1_addr = w_addr[1]; m1_wdata = w_wdat[1];
            Cpu_data4bus = bus_rd[c];

            // Arbiter is free and someone asks: schedule the whole transaction.
            if (c >= free_at && (r[0] || r[1])) begin
                if (r[0] && r[1]) win = 1 - mlast;
                else if (r[0])    win = 0;
                else              win = 1;
                mlast = win;
                for (int k = 1; k <= AC; k++) begin
                    tl[c+k].mem_w = w_we[win];
                    tl[c+k].mem_r = !w_we[win];
                    tl[c+k].addr  = w_addr[win];
                    tl[c+k].wdata = w_wdat[win];
                    tl[c+k].owner = 1'(win);
                    tl[c+k].busy  = 1'b1;
                end
                tl[c+AC+1].ack0  = (win == 0);
                tl[c+AC+1].ack1  = (win == 1);
                tl[c+AC+1].owner = 1'(win);
                tl[c+AC+1].busy  = 1'b1;
                tl[c+AC+1].rdata = bus_rd[c+AC];
                flight[win] = 1'b1;
                ack_at[win] = c + AC + 1;
                free_at     = c + AC + 2;
            end
        end
        m0_req = 1'b0;
        m1_req = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // ---- reset values ----
        do_reset();
        check("rst_bus", bus_now(), 66'd0);
        check("rst_ctl", ctl_now(), 4'b0000);
        check("rst_rdata", {m0_rdata, m1_rdata}, 64'd0);

        // ---- single read by m0 ----
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h0000_0010; m0_wdata = 32'hA5A5_0000;
        Cpu_data4bus = 32'hDEAD_BEEF;
        @(negedge clk);
        check("rd_acc1_bus", bus_now(), {1'b0, 1'b1, 32'h0000_0010, 32'hA5A5_0000});
        check("rd_acc1_ctl", ctl_now(), 4'b0001);
        @(negedge clk);
        check("rd_acc2_bus", bus_now(), {1'b0, 1'b1, 32'h0000_0010, 32'hA5A5_0000});
        @(negedge clk);
        check("rd_done_ctl", ctl_now(), 4'b1001);
        check("rd_done_bus", bus_now(), 66'd0);
        check("rd_rdata", m0_rdata, 32'hDEAD_BEEF);
        m0_req = 1'b0;
        @(negedge clk);
        check("rd_idle_ctl", ctl_now(), 4'b0000);

        // ---- single write by m1 ----
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'hFFFF_FF00; m1_wdata = 32'h1234_5678;
        Cpu_data4bus = 32'hCAFE_F00D;
        @(negedge clk);
        check("wr_acc1_bus", bus_now(), {1'b1, 1'b0, 32'hFFFF_FF00, 32'h1234_5678});
        check("wr_acc1_ctl", ctl_now(), 4'b0011);
        @(negedge clk);
        check("wr_acc2_bus", bus_now(), {1'b1, 1'b0, 32'hFFFF_FF00, 32'h1234_5678});
        @(negedge clk);
        check("wr_done_ctl", ctl_now(), 4'b0111);
        check("wr_done_bus", bus_now(), 66'd0);
        check("wr_m0_hold", m0_rdata, 32'hDEAD_BEEF);
        m1_req = 1'b0;

        // ---- tie after reset: m0 first, m1 right after ----
        do_reset();
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h0000_0100;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h0000_0200;
        @(negedge clk);                                            // t+1
        check("tie_first_owner", {owner, addr_bus}, {1'b0, 32'h0000_0100});
        repeat (2) @(negedge clk);                                 // t+3
        check("tie_ack0", ctl_now(), 4'b1001);
        m0_req = 1'b0;
        @(negedge clk);                                            // t+4
        check("tie_idle", ctl_now(), 4'b0000);
        @(negedge clk);                                            // t+5
        check("tie_second_owner", {owner, addr_bus}, {1'b1, 32'h0000_0200});
        repeat (2) @(negedge clk);                                 // t+7
        check("tie_ack1", ctl_now(), 4'b0111);
        m1_req = 1'b0;
        @(negedge clk);

        // ---- input change mid-access, then reset in 2nd ACCESS cycle ----
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h0000_0040;
        @(negedge clk);                                            // t+1
        check("chg_acc1_addr", addr_bus, 32'h0000_0040);
        m0_addr = 32'h0000_BAD0;
        @(negedge clk);                                            // t+2
        check("chg_acc2_addr", addr_bus, 32'h0000_0040);
        rst = 1'b1;
        @(negedge clk);                                            // t+3
        check("abort_bus", bus_now(), 66'd0);
        check("abort_ctl", ctl_now(), 4'b0000);
        rst = 1'b0;
        m0_addr = 32'h0000_0300;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h0000_0400;
        @(negedge clk);                                            // t+4
        check("abort_tie_owner", {owner, addr_bus}, {1'b0, 32'h0000_0300});
        repeat (2) @(negedge clk);                                 // t+6
        check("abort_tie_ack", ctl_now(), 4'b1001);
        m0_req = 1'b0;
        repeat (4) @(negedge clk);                                 // t+10
        check("abort_tie_ack1", ctl_now(), 4'b0111);
        m1_req = 1'b0;

        // ---- continuous contention (>= 6 transactions), then random traffic ----
        run_engine("contend", 6 * (AC + 2) + 4, 100);
        run_engine("random", 1500, 40);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
